// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: loads a scan pattern, optionally pulses capture, then unloads and compares the response under a mask
module scan_chain_ctrl #(
  parameter int CHAIN_LEN  = 4,
  parameter int CAP_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 capture_en,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic [CHAIN_LEN-1:0] mask,
  input  logic                 chain_so,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] captured
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, CAPTURE = 3'd2, UNLOAD = 3'd3, DONE = 3'd4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CAP = CNT_W'(CAP_CYCLES - 1);
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pat_q, exp_q, mask_q, cap_next;
  logic                 cap_en_q;
  assign cap_next = {captured[CHAIN_LEN-2:0], chain_so};
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  // pat_q holds the not-yet-sent bits left-aligned, so the next bit is always its MSB
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pat_q    <= '0;
      exp_q    <= '0;
      mask_q   <= '0;
      cap_en_q <= 1'b0;
      scan_en  <= 1'b0;
      scan_in  <= 1'b0;
      pass     <= 1'b0;
      captured <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= LOAD;
          cnt      <= '0;
          pat_q    <= pattern << 1;
          exp_q    <= expected;
          mask_q   <= mask;
          cap_en_q <= capture_en;
          scan_en  <= 1'b1;
          scan_in  <= pattern[CHAIN_LEN-1];
          pass     <= 1'b0;
          captured <= '0;
        end
        LOAD: if (cnt == LAST_BIT) begin
          cnt     <= '0;
          scan_in <= 1'b0;
          scan_en <= !cap_en_q;
          state   <= cap_en_q ? CAPTURE : UNLOAD;
        end else begin
          cnt     <= cnt + CNT_W'(1);
          scan_in <= pat_q[CHAIN_LEN-1];
          pat_q   <= pat_q << 1;
        end
        CAPTURE: if (cnt == LAST_CAP) begin
          cnt     <= '0;
          scan_en <= 1'b1;
          state   <= UNLOAD;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        UNLOAD: begin
          captured <= cap_next;
          if (cnt == LAST_BIT) begin
            cnt     <= '0;
            scan_en <= 1'b0;
            pass    <= ((cap_next ^ exp_q) & mask_q) == '0;
            state   <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed tests against a cycle-indexed reference model and a behavioural 4-bit scan chain
module tb_scan_chain_ctrl;
  localparam int L = 4, C = 1;
  logic clk = 1'b0, rst, start = 1'b0, capture_en = 1'b0;
  logic [L-1:0] pattern = '0, expected = '0, mask = '0, captured;
  logic chain_so, scan_en, scan_in, busy, done, pass;
  logic [L-1:0] chain = '0;
  logic [L-1:0] d_val = 4'b0110;
  int n_chk = 0, n_pass = 0, cyc = 0, done_cnt = 0;
  bit chk_on = 0;

  scan_chain_ctrl #(.CHAIN_LEN(L), .CAP_CYCLES(C), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .capture_en(capture_en),
    .pattern(pattern), .expected(expected), .mask(mask), .chain_so(chain_so),
    .scan_en(scan_en), .scan_in(scan_in), .busy(busy), .done(done),
    .pass(pass), .captured(captured)
  );

  always #5 clk = ~clk;
  assign chain_so = chain[L-1];
  // shift when enabled, otherwise the functional path loads d_val
  always @(posedge clk) chain <= scan_en ? {chain[L-2:0], scan_in} : d_val;
  always @(posedge clk) cyc++;

  // model: m_k counts edges since the accepting edge; phases follow from arithmetic on m_k
  bit m_act = 0;
  int m_k = 0;
  logic m_cap = 0, m_res_pass = 0;
  logic [L-1:0] m_pat = '0, m_exp = '0, m_msk = '0, m_res_cap = '0;
  function automatic int ls_f(); return L + (m_cap ? C : 0); endfunction
  function automatic int kd_f(); return ls_f() + L; endfunction
  function automatic logic [L-1:0] res_f(); return m_cap ? d_val : m_pat; endfunction

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_act = 0; m_k = 0; m_res_cap = '0; m_res_pass = 0;
    end else if (m_act) begin
      if (m_k == kd_f()) m_act = 0;
      else begin
        m_k++;
        if (m_k == kd_f()) begin
          m_res_cap = res_f();
          m_res_pass = ((m_res_cap ^ m_exp) & m_msk) == '0;
        end
      end
    end else if (start) begin
      m_act = 1; m_k = 0; m_cap = capture_en;
      m_pat = pattern; m_exp = expected; m_msk = mask;
      m_res_cap = '0; m_res_pass = 0;
    end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (chk_on) begin
      logic e_se, e_si, e_dn, e_ps;
      logic [L-1:0] e_cp;
      e_dn = m_act && m_k == kd_f();
      e_se = m_act && (m_k < L || (m_k >= ls_f() && m_k < kd_f()));
      e_si = m_act && m_k < L ? m_pat[L-1-m_k] : 1'b0;
      e_cp = !m_act || e_dn ? m_res_cap : (m_k >= ls_f() ? res_f() >> (L - (m_k - ls_f())) : '0);
      e_ps = !m_act || e_dn ? m_res_pass : 1'b0;
      check("busy", 32'(busy), 32'(m_act));
      check("done", 32'(done), 32'(e_dn));
      check("scan_en", 32'(scan_en), 32'(e_se));
      check("scan_in", 32'(scan_in), 32'(e_si));
      check("captured", 32'(captured), 32'(e_cp));
      check("pass", 32'(pass), 32'(e_ps));
    end
  end

  task automatic run(input logic ce, input logic [L-1:0] p, input logic [L-1:0] e,
                     input logic [L-1:0] m, input bit noisy, input logic [L-1:0] want_cap,
                     input logic want_pass, input int want_lat);
    int n0, d0, lat;
    bit got;
    got = 0; lat = -1;
    d0 = done_cnt;
    @(posedge clk); #2;
    capture_en = ce; pattern = p; expected = e; mask = m; start = 1;
    @(posedge clk); #2;
    n0 = cyc; start = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) begin got = 1; lat = cyc - n0; end
      else if (noisy) begin
        start = 1; capture_en = ~ce; pattern = ~p; expected = ~e; mask = '0;
      end
    end
    @(posedge clk); #2;
    start = 0;
    if (!got) check("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("latency", 32'(lat), 32'(want_lat));
    check("captured_lit", 32'(captured), 32'(want_cap));
    check("pass_lit", 32'(pass), 32'(want_pass));
    check("done_pulses", 32'(done_cnt - d0), 1);
  endtask

  initial begin
    int d0;
    rst = 0;
    @(posedge clk); #1;
    chk_on = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      start = ~start; capture_en = ~capture_en; pattern = 4'(i);
    end
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_captured", 32'(captured), 0);
    start = 0;
    @(posedge clk); #2;
    rst = 1;
    run(1'b0, 4'b1011, 4'b1011, 4'hF, 0, 4'b1011, 1'b1, 8);
    run(1'b1, 4'b1011, 4'b0110, 4'hF, 0, 4'b0110, 1'b1, 9);
    run(1'b1, 4'b1011, 4'b0111, 4'hF, 0, 4'b0110, 1'b0, 9);
    run(1'b1, 4'b1011, 4'b0111, 4'b1110, 0, 4'b0110, 1'b1, 9);
    run(1'b1, 4'b1011, 4'b0110, 4'hF, 1, 4'b0110, 1'b1, 9);
    run(1'b0, 4'b0101, 4'b0101, 4'hF, 1, 4'b0101, 1'b1, 8);
    run(1'b1, 4'b1011, 4'b1001, 4'h0, 0, 4'b0110, 1'b1, 9);
    // reset while the second unload bit is pending
    @(posedge clk); #2;
    capture_en = 1; pattern = 4'b1011; expected = 4'b0110; mask = 4'hF; start = 1;
    @(posedge clk); #2;
    start = 0;
    repeat (6) @(posedge clk);
    #2;
    d0 = done_cnt;
    rst = 0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_scan_en", 32'(scan_en), 0);
    check("midrst_captured", 32'(captured), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - d0), 0);
    run(1'b0, 4'b1100, 4'b1100, 4'hF, 0, 4'b1100, 1'b1, 8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Tester-side controller for one scan chain: serially loads a test pattern, optionally pulses one or more functional capture cycles, then unloads the chain response and compares it against an expected vector under a mask.
- It drives the chain's scan_en/scan_in and receives the chain's scan_out (chain_so).
- It sits between the test sequencer (start/pattern/expected) and a scan-inserted register.

Parameters:
CHAIN_LEN, 4, number of flops in the scan chain (>=2)
CAP_CYCLES, 1, functional capture cycles with scan_en=0 (>=1)
CNT_W, 8, counter width; must hold max(CHAIN_LEN, CAP_CYCLES)

Ports:
clk  input  1  rising-edge clock, shared with the scan chain
rst  input  1  asynchronous reset, active-low
start  input  1  request a test; sampled only in IDLE
capture_en  input  1  1: LOAD->CAPTURE->UNLOAD; 0: LOAD->UNLOAD (chain integrity/flush test); latched with start
pattern  input  CHAIN_LEN  load vector; latched on accepted start
expected  input  CHAIN_LEN  expected unload vector; latched on accepted start
mask  input  CHAIN_LEN  1 = compare bit, 0 = don't care; latched on accepted start
chain_so  input  1  scan_out of the chain
scan_en  output  1  chain scan enable, registered
scan_in  output  1  chain serial input, registered
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when result is valid
pass  output  1  ((captured ^ exp) & mask) == 0; held until next accepted start
captured  output  CHAIN_LEN  unloaded response; held until next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; scan_en, scan_in, busy, done and pass = 0; captured = 0; counters = 0.
- Shift order: pattern is sent MSB first, so pattern[CHAIN_LEN-1] is on scan_in for the first shift edge. Unload is also MSB first: the first chain_so sample becomes captured[CHAIN_LEN-1]. The first bit in is therefore the first bit out.
- The chain shifts on every rising edge where scan_en=1. scan_en/scan_in are registered and change only on the edge where the state or bit index changes.
- FSM states: IDLE, LOAD, CAPTURE, UNLOAD, DONE.
- IDLE:
  - scan_en=0, scan_in=0.
  - At an edge with start=1 (call it edge n): latch pattern, expected, mask and capture_en; clear pass and captured; go to LOAD with scan_en=1, scan_in=pattern[CHAIN_LEN-1].
- LOAD:
  - CHAIN_LEN shift edges (n+1 .. n+L, where L=CHAIN_LEN). scan_in advances to the next lower pattern bit after each edge.
  - After edge n+L: go to CAPTURE (scan_en=0) if capture_en=1, else straight to UNLOAD.
  - scan_in=0 in every state other than LOAD.
- CAPTURE:
  - scan_en=0 for exactly CAP_CYCLES edges (capture edges n+L+1 .. n+L+C, where C=CAP_CYCLES), then go to UNLOAD with scan_en=1.
- UNLOAD:
  - CHAIN_LEN edges with scan_en=1 and scan_in=0 (zero fill).
  - At each of these edges, chain_so is shifted into captured from the LSB side. The first sample is taken at the first UNLOAD edge, before the chain has shifted.
  - At the last UNLOAD edge: go to DONE, scan_en=0. pass is registered using the final captured value, including the bit sampled on that same edge.
- DONE:
  - done=1 for exactly one cycle; pass and captured are valid; busy=1.
  - Next edge returns to IDLE. A start seen on this edge is ignored; start is accepted from IDLE only.
- Latency: done is high in the cycle after edge n+2L+C (capture_en=1) or n+2L (capture_en=0).
- start while busy: ignored, and the latched inputs do not change. Input changes after acceptance have no effect.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values. No partial done is produced.
- mask=0: pass=1 regardless of captured.

Test Plan:
- Reset: hold rst=0 with start=1 toggling -> scan_en=0, scan_in=0, busy=0, done=0, pass=0, captured=0 throughout.
- Flush test:
  - Setup: CHAIN_LEN=4 behavioral chain; capture_en=0, pattern=4'b1011, expected=4'b1011, mask=4'hF.
  - Required: scan_in sequence 1,0,1,1 on LOAD edges; captured=1011; pass=1; done pulses once, in the cycle after edge n+8.
- Capture test:
  - Setup: chain parallel-loads D=4'b0110 when scan_en=0; capture_en=1, CAP_CYCLES=1, pattern=4'b1011, expected=4'b0110, mask=4'hF.
  - Required: scan_en low for exactly 1 edge between LOAD and UNLOAD; captured=0110; pass=1; done in the cycle after edge n+9.
- Mismatch and mask:
  - Same setup as the capture test with expected=4'b0111, mask=4'hF -> pass=0.
  - Repeat with mask=4'b1110 -> pass=1.
  - captured=0110 in both cases.
- start re-asserted during LOAD/UNLOAD/DONE with a different pattern -> ignored; result matches the original latched vectors; done pulses exactly once.
- rst pulsed low during UNLOAD (2nd bit) -> immediate IDLE, scan_en=0, busy=0, no done. A following fresh start completes normally with the correct result.
